// File: rtl/plane_draw_scheduler.sv
// Per-frame erase/move/draw sequencer that shares one VGA plot port among N_PLANES sprites.
// Optional build macro: PLANE_DRAW_SCHED_SLOT_COLOUR_EN gives each slot its own draw colour.
module plane_draw_scheduler #(
  parameter int                 N_PLANES     = 10,
  parameter int                 SPR_W        = 4,
  parameter int                 SPR_H        = 4,
  parameter int                 COLOR_W      = 3,
  parameter logic [COLOR_W-1:0] PLANE_COLOUR = COLOR_W'(3'b111)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_tick,
  input  logic [N_PLANES-1:0]   vis,
  input  logic [8*N_PLANES-1:0] x_flat,
  input  logic [8*N_PLANES-1:0] y_flat,
  output logic                  move_en,
  output logic                  plot,
  output logic [7:0]            plot_x,
  output logic [7:0]            plot_y,
  output logic [COLOR_W-1:0]    plot_colour,
  output logic                  busy,
  output logic                  frame_overrun
);

  localparam int SLOT_W = (N_PLANES > 1) ? $clog2(N_PLANES) : 1;
  localparam int PX_W   = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int PY_W   = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERASE = 2'd1,
    MOVE  = 2'd2,
    DRAW  = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic [SLOT_W-1:0]   slot_r, slot_s;
  logic [PX_W-1:0]     px_r, px_s;
  logic [PY_W-1:0]     py_r, py_s;
  logic [N_PLANES-1:0] drawn_mask_r;
  logic [N_PLANES-1:0] snap_r;
  logic [N_PLANES-1:0] cur_mask_s;
  logic [N_PLANES-1:0] next_mask_s;
  logic                slot_done_s;
  logic                last_px_s, last_py_s, last_slot_s;

  logic                move_en_r, plot_r, busy_r, frame_overrun_r;
  logic [7:0]          plot_x_r, plot_y_r;
  logic [COLOR_W-1:0]  plot_colour_r;

  logic                plot_s;
  logic [7:0]          x_sel_s, y_sel_s;
  logic [7:0]          plot_x_s, plot_y_s;
  logic [COLOR_W-1:0]  plot_colour_s;

  assign move_en       = move_en_r;
  assign plot          = plot_r;
  assign plot_x        = plot_x_r;
  assign plot_y        = plot_y_r;
  assign plot_colour   = plot_colour_r;
  assign busy          = busy_r;
  assign frame_overrun = frame_overrun_r;

  // Next-state sequencing over slots and sprite raster
  always_comb begin
    state_s     = state_r;
    slot_s      = slot_r;
    px_s        = px_r;
    py_s        = py_r;
    cur_mask_s  = (state_r == DRAW) ? snap_r : drawn_mask_r;
    last_px_s   = (px_r == PX_W'(SPR_W - 1));
    last_py_s   = (py_r == PY_W'(SPR_H - 1));
    last_slot_s = (slot_r == SLOT_W'(N_PLANES - 1));
    slot_done_s = !cur_mask_s[slot_r] || (last_px_s && last_py_s);
    case (state_r)
      IDLE: begin
        if (frame_tick) begin
          state_s = ERASE;
          slot_s  = {SLOT_W{1'b0}};
          px_s    = {PX_W{1'b0}};
          py_s    = {PY_W{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      ERASE, DRAW: begin
        if (slot_done_s) begin
          px_s = {PX_W{1'b0}};
          py_s = {PY_W{1'b0}};
          if (last_slot_s) begin
            state_s = (state_r == ERASE) ? MOVE : IDLE;
            slot_s  = {SLOT_W{1'b0}};
          end else begin
            slot_s = slot_r + SLOT_W'(1);
          end
        end else if (last_px_s) begin
          px_s = {PX_W{1'b0}};
          py_s = py_r + PY_W'(1);
        end else begin
          px_s = px_r + PX_W'(1);
        end
      end
      MOVE: begin
        state_s = DRAW;
        slot_s  = {SLOT_W{1'b0}};
        px_s    = {PX_W{1'b0}};
        py_s    = {PY_W{1'b0}};
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Output values for the cycle being entered; the draw mask is taken live from vis on the MOVE edge
  always_comb begin
    next_mask_s   = {N_PLANES{1'b0}};
    plot_x_s      = 8'd0;
    plot_y_s      = 8'd0;
    plot_colour_s = {COLOR_W{1'b0}};
    case (state_s)
      ERASE:   next_mask_s = drawn_mask_r;
      DRAW:    next_mask_s = (state_r == MOVE) ? vis : snap_r;
      default: next_mask_s = {N_PLANES{1'b0}};
    endcase
    plot_s  = ((state_s == ERASE) || (state_s == DRAW)) && next_mask_s[slot_s];
    x_sel_s = x_flat[{slot_s, 3'b000} +: 8];
    y_sel_s = y_flat[{slot_s, 3'b000} +: 8];
    if (plot_s) begin
      plot_x_s = x_sel_s + 8'(px_s);
      plot_y_s = y_sel_s + 8'(py_s);
      if (state_s == DRAW) begin
`ifdef PLANE_DRAW_SCHED_SLOT_COLOUR_EN
        plot_colour_s = COLOR_W'((32'(slot_s) % 32'd7) + 32'd1);
`else
        plot_colour_s = PLANE_COLOUR;
`endif
      end else begin
        plot_colour_s = {COLOR_W{1'b0}};
      end
    end else begin
      plot_x_s = 8'd0;
    end
  end

  // State, counters, masks and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= IDLE;
      slot_r          <= {SLOT_W{1'b0}};
      px_r            <= {PX_W{1'b0}};
      py_r            <= {PY_W{1'b0}};
      drawn_mask_r    <= {N_PLANES{1'b0}};
      snap_r          <= {N_PLANES{1'b0}};
      move_en_r       <= 1'b0;
      plot_r          <= 1'b0;
      busy_r          <= 1'b0;
      frame_overrun_r <= 1'b0;
      plot_x_r        <= 8'd0;
      plot_y_r        <= 8'd0;
      plot_colour_r   <= {COLOR_W{1'b0}};
    end else begin
      state_r         <= state_s;
      slot_r          <= slot_s;
      px_r            <= px_s;
      py_r            <= py_s;
      if (state_r == MOVE) begin
        snap_r       <= vis;
        drawn_mask_r <= vis;
      end else begin
        snap_r       <= snap_r;
        drawn_mask_r <= drawn_mask_r;
      end
      move_en_r       <= (state_s == MOVE);
      plot_r          <= plot_s;
      busy_r          <= (state_s != IDLE);
      frame_overrun_r <= frame_tick && (state_r != IDLE);
      plot_x_r        <= plot_x_s;
      plot_y_r        <= plot_y_s;
      plot_colour_r   <= plot_colour_s;
    end
  end

endmodule

// File: tb/tb_plane_draw_scheduler.sv
// Frame-level bench: each table row is one frame; a pixel-list model fills a scoreboard that is drained per cycle.
module tb_plane_draw_scheduler;

  localparam int NP = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_tick;
  logic [NP-1:0] vis;
  logic [8*NP-1:0] x_flat, y_flat;
  logic          move_en, plot, busy, frame_overrun;
  logic [7:0]    plot_x, plot_y;
  logic [2:0]    plot_colour;

  logic [7:0] xs [NP];
  logic [7:0] ys [NP];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NP; i++) begin
      x_flat[8*i +: 8] = xs[i];
      y_flat[8*i +: 8] = ys[i];
    end
  end

  plane_draw_scheduler dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .vis(vis),
    .x_flat(x_flat), .y_flat(y_flat), .move_en(move_en), .plot(plot),
    .plot_x(plot_x), .plot_y(plot_y), .plot_colour(plot_colour),
    .busy(busy), .frame_overrun(frame_overrun)
  );

  typedef struct {
    logic [NP-1:0] vis;
    logic [7:0]    xb;
    logic [7:0]    yb;
    logic [7:0]    dy;
    int            ovr_at;
    int            rst_at;
    int            exp_len;
  } frame_t;

  typedef struct {
    logic       plot;
    logic [7:0] x;
    logic [7:0] y;
    logic [2:0] col;
    logic       move_en;
  } exp_t;

  exp_t          sb[$];
  frame_t        frames [9];
  logic [NP-1:0] drawn_m;
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] col_of(input int s);
`ifdef PLANE_DRAW_SCHED_SLOT_COLOUR_EN
    return 3'((s % 7) + 1);
`else
    s = s;
    return 3'b111;
`endif
  endfunction

  task automatic push_phase(input logic [NP-1:0] mask, input logic [7:0] dy, input logic erase);
    exp_t e;
    for (int s = 0; s < NP; s++) begin
      if (mask[s]) begin
        for (int py = 0; py < 4; py++)
          for (int px = 0; px < 4; px++) begin
            e.plot = 1'b1; e.move_en = 1'b0;
            e.x = xs[s] + 8'(px);
            e.y = ys[s] + dy + 8'(py);
            e.col = erase ? 3'd0 : col_of(s);
            sb.push_back(e);
          end
      end else begin
        e = '{1'b0, 8'd0, 8'd0, 3'd0, 1'b0};
        sb.push_back(e);
      end
    end
  endtask

  task automatic run_frame(input int fi, input frame_t r);
    exp_t e;
    int   n, busy_cnt;
    for (int i = 0; i < NP; i++) begin
      xs[i] = r.xb + 8'(i * 37);
      ys[i] = r.yb + 8'(i * 23);
    end
    vis = r.vis;
    sb.delete();
    push_phase(drawn_m, 8'd0, 1'b1);
    e = '{1'b0, 8'd0, 8'd0, 3'd0, 1'b1};
    sb.push_back(e);
    push_phase(r.vis, r.dy, 1'b0);
    n = sb.size();
    busy_cnt = 0;
    frame_tick = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      frame_tick = (k == r.ovr_at);
      e = sb.pop_front();
      if (busy) busy_cnt++;
      check($sformatf("f%0d c%0d plot", fi, k), int'(plot), int'(e.plot));
      check($sformatf("f%0d c%0d move_en", fi, k), int'(move_en), int'(e.move_en));
      check($sformatf("f%0d c%0d overrun", fi, k), int'(frame_overrun),
            int'(k > 0 && (k - 1) == r.ovr_at));
      if (e.plot && plot) begin
        check($sformatf("f%0d c%0d plot_x", fi, k), int'(plot_x), int'(e.x));
        check($sformatf("f%0d c%0d plot_y", fi, k), int'(plot_y), int'(e.y));
        check($sformatf("f%0d c%0d colour", fi, k), int'(plot_colour), int'(e.col));
      end
      if (k == r.rst_at) begin
        reset = 1'b1;
        @(negedge clk);
        check($sformatf("f%0d reset plot", fi), int'(plot), 0);
        check($sformatf("f%0d reset busy", fi), int'(busy), 0);
        check($sformatf("f%0d reset move_en", fi), int'(move_en), 0);
        reset = 1'b0;
        sb.delete();
        drawn_m = '0;
        return;
      end
      if (e.move_en)
        for (int i = 0; i < NP; i++) ys[i] = ys[i] + r.dy;
    end
    @(negedge clk);
    frame_tick = 1'b0;
    check($sformatf("f%0d end busy", fi), int'(busy), 0);
    check($sformatf("f%0d end plot", fi), int'(plot), 0);
    check($sformatf("f%0d end overrun", fi), int'(frame_overrun), int'(r.ovr_at == n - 1));
    check($sformatf("f%0d frame length", fi), busy_cnt, r.exp_len);
    @(negedge clk);
    check($sformatf("f%0d idle busy", fi), int'(busy), 0);
    check($sformatf("f%0d idle overrun", fi), int'(frame_overrun), 0);
    drawn_m = r.vis;
  endtask

  initial begin
    //            vis            xb      yb      dy    ovr  rst  len
    frames[0] = '{10'b0,         8'd0,   8'd0,   8'd1, -1,  -1,  21};
    frames[1] = '{10'b1,         8'd20,  8'd30,  8'd0, -1,  -1,  36};
    frames[2] = '{10'b1,         8'd20,  8'd30,  8'd1, -1,  -1,  51};
    frames[3] = '{10'b1000,      8'd143, 8'd200, 8'd0, -1,  -1,  51};
    frames[4] = '{10'b1010010101,8'd250, 8'd250, 8'd3, 40,  -1,  111};
    frames[5] = '{10'h3FF,       8'd5,   8'd240, 8'd2, -1,  -1,  246};
    frames[6] = '{10'b0,         8'd0,   8'd0,   8'd0, 170, -1,  171};
    frames[7] = '{10'h3FF,       8'd60,  8'd70,  8'd1, -1,  50,  171};
    frames[8] = '{10'b11,        8'd60,  8'd70,  8'd1, -1,  -1,  51};

    reset = 1'b1;
    frame_tick = 1'b0;
    vis = '0;
    for (int i = 0; i < NP; i++) begin
      xs[i] = 8'd0;
      ys[i] = 8'd0;
    end
    drawn_m = '0;
    repeat (2) @(negedge clk);
    check("reset plot", int'(plot), 0);
    check("reset busy", int'(busy), 0);
    check("reset move_en", int'(move_en), 0);
    check("reset overrun", int'(frame_overrun), 0);
    check("reset plot_x", int'(plot_x), 0);
    check("reset plot_y", int'(plot_y), 0);
    check("reset colour", int'(plot_colour), 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle busy", int'(busy), 0);

    for (int f = 0; f < 9; f++) run_frame(f, frames[f]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
